// File: rtl/datapath_pkg.sv
// datapath_pkg: constants shared by the scheduled-datapath blocks.
//   - default operand / count widths
//   - prod_accum state encoding (2-bit binary)
package datapath_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ACCUM = 2'd1;
  localparam state_t S_DONE  = 2'd2;

endpackage

// File: rtl/prod_accum.sv
// prod_accum: sequential accumulator behind the datapath multiplier.
// Sums `len` unsigned 2*WIDTH-bit products into an ACC_W-bit result.
//
// Ports
//   Clk        clock, rising edge
//   Rst        asynchronous reset, active low
//   start/len  begin a run of len terms (sampled in IDLE only)
//   in_valid/in_ready/prod    product stream (ready only in ACCUM)
//   out_valid/out_ready/acc   result handshake (valid only in DONE)
//   ovf        sticky carry-out of ACC_W during the current run
//   busy       high in ACCUM and DONE
//
// Build option
//   PROD_ACCUM_SAT_EN  defined: acc saturates to all-ones on overflow.
//                      undefined: acc wraps modulo 2**ACC_W.
//   ovf and handshake timing are the same in both builds.
module prod_accum
  import datapath_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = 2*WIDTH+8,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   prod,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_W-1:0]     acc,
  output logic                 ovf,
  output logic                 busy
);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q,   acc_d;
  logic               ovf_q,   ovf_d;
  logic [CNT_W-1:0]   rem_q,   rem_d;

  // One extra bit so the carry out of ACC_W is visible.
  logic [ACC_W:0]     sum;

  assign sum = {1'b0, acc_q} + {{(ACC_W+1-2*WIDTH){1'b0}}, prod};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          rem_d   = len;
          state_d = (len == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        // in_ready is 1 throughout ACCUM, so a beat is just in_valid.
        if (in_valid) begin
          if (sum[ACC_W]) ovf_d = 1'b1;
`ifdef PROD_ACCUM_SAT_EN
          acc_d = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
          acc_d = sum[ACC_W-1:0];
`endif
          rem_d = rem_q - 1'b1;
          if (rem_q == {{(CNT_W-1){1'b0}}, 1'b1}) state_d = S_DONE;
        end
      end
      S_DONE: begin
        // start in the handshake cycle is dropped: we only leave to IDLE.
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      rem_q   <= rem_d;
    end
  end

  // Flags decode straight from the state register.
  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_ACCUM) || (state_q == S_DONE);
  assign acc       = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_prod_accum.sv
// tb_prod_accum: directed vector table plus hand-written multi-cycle
// sequences and a randomized run against a reference sum.
// Two instances share every input: default widths (ACC_W=24) and ACC_W=16.
module tb_prod_accum;

  localparam int W  = 8;
  localparam int AW = 24;
  localparam int AS = 16;
  localparam int CW = 8;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          start, in_valid, out_ready;
  logic [CW-1:0] len;
  logic [2*W-1:0] prod;

  logic          in_ready, out_valid, ovf, busy;
  logic [AW-1:0] acc;
  logic          in_ready_s, out_valid_s, ovf_s, busy_s;
  logic [AS-1:0] acc_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  prod_accum #(.WIDTH(W), .ACC_W(AW), .CNT_W(CW)) u_dut (
    .Clk(Clk), .Rst(Rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .prod(prod),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc(acc), .ovf(ovf), .busy(busy));

  prod_accum #(.WIDTH(W), .ACC_W(AS), .CNT_W(CW)) u_dut16 (
    .Clk(Clk), .Rst(Rst), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready_s), .prod(prod),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .acc(acc_s), .ovf(ovf_s), .busy(busy_s));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    string          tag;
    logic           st;
    logic [CW-1:0]  ln;
    logic           iv;
    logic [2*W-1:0] pr;
    logic           ordy;
    logic           e_ir;
    logic           e_ov;
    logic           e_busy;
    logic [AW-1:0]  e_acc;
    logic           e_ovf;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input string tag, input logic st, input int ln,
                              input logic iv, input int pr, input logic ordy,
                              input logic e_ir, input logic e_ov, input logic e_busy,
                              input int e_acc, input logic e_ovf);
    vec_t v;
    v.tag = tag; v.st = st; v.ln = ln[CW-1:0]; v.iv = iv; v.pr = pr[2*W-1:0];
    v.ordy = ordy; v.e_ir = e_ir; v.e_ov = e_ov; v.e_busy = e_busy;
    v.e_acc = e_acc[AW-1:0]; v.e_ovf = e_ovf;
    vq.push_back(v);
  endfunction

  task automatic idle_inputs();
    start = 0; len = '0; in_valid = 0; prod = '0; out_ready = 0;
  endtask

  task automatic pop(input string nm);
    @(negedge Clk);
    out_ready = 1;
    @(posedge Clk); #1;
    chk({nm, "_pop_ov"}, out_valid, 1'b0);
    @(negedge Clk);
    out_ready = 0;
  endtask

  task automatic run_rand(input int ln);
    logic [AW:0] s24;
    logic [AS:0] s16;
    logic [AW-1:0] m24;
    logic [AS-1:0] m16;
    logic o24, o16, ir, iv;
    logic [2*W-1:0] p;
    int beats, cyc;
    m24 = '0; m16 = '0; o24 = 0; o16 = 0; beats = 0; cyc = 0;
    @(negedge Clk);
    start = 1; len = ln[CW-1:0];
    while (beats < ln && cyc < 4*ln + 50) begin
      @(negedge Clk);
      start = 0;
      ir = in_ready;
      iv = ($urandom % 4) != 0;
      p  = $urandom;
      in_valid = iv; prod = p;
      if (iv && ir) begin
        beats++;
        s24 = {1'b0, m24} + {{(AW+1-2*W){1'b0}}, p};
        s16 = {1'b0, m16} + {1'b0, p};
        if (s24[AW]) o24 = 1;
        if (s16[AS]) o16 = 1;
`ifdef PROD_ACCUM_SAT_EN
        m24 = s24[AW] ? {AW{1'b1}} : s24[AW-1:0];
        m16 = s16[AS] ? {AS{1'b1}} : s16[AS-1:0];
`else
        m24 = s24[AW-1:0];
        m16 = s16[AS-1:0];
`endif
      end
      cyc++;
    end
    @(negedge Clk);
    in_valid = 0;
    chk("rand_beats", beats, ln);
    chk("rand_ov",    out_valid, 1'b1);
    chk("rand_acc",   acc, m24);
    chk("rand_ovf",   ovf, o24);
    chk("rand_ov16",  out_valid_s, 1'b1);
    chk("rand_acc16", acc_s, m16);
    chk("rand_ovf16", ovf_s, o16);
    pop("rand");
  endtask

  initial begin
    idle_inputs();
    Rst = 0;

    // tag, st, len, iv, prod, ordy | in_ready, out_valid, busy, acc, ovf
    // t1: three back-to-back beats
    add("t1_start", 1, 3, 0,  0, 0,  1, 0, 1,  0, 0);
    add("t1_b1",    0, 0, 1,  6, 0,  1, 0, 1,  6, 0);
    add("t1_b2",    0, 0, 1, 20, 0,  1, 0, 1, 26, 0);
    add("t1_b3",    0, 0, 1, 42, 0,  0, 1, 1, 68, 0);
    add("t1_hold",  1, 9, 1, 99, 0,  0, 1, 1, 68, 0);
    add("t1_pop",   0, 0, 0,  0, 1,  0, 0, 0, 68, 0);
    // t2: len==0 goes straight to DONE
    add("t2_start", 1, 0, 1,  7, 0,  0, 1, 1,  0, 0);
    add("t2_pop",   0, 0, 0,  0, 1,  0, 0, 0,  0, 0);
    add("t2_idle",  0, 0, 0,  0, 0,  0, 0, 0,  0, 0);
    // t4: len=4 with gaps 3,0,1,2; start/len/prod noise while not a beat
    add("t4_start", 1, 4, 0,  0, 0,  1, 0, 1,  0, 0);
    add("t4_g0",    1, 1, 0, 50, 0,  1, 0, 1,  0, 0);
    add("t4_g1",    0, 0, 0, 60, 0,  1, 0, 1,  0, 0);
    add("t4_g2",    1, 2, 0, 70, 0,  1, 0, 1,  0, 0);
    add("t4_b1",    0, 0, 1,  5, 0,  1, 0, 1,  5, 0);
    add("t4_b2",    0, 0, 1,  7, 0,  1, 0, 1, 12, 0);
    add("t4_g3",    1, 1, 0,500, 0,  1, 0, 1, 12, 0);
    add("t4_b3",    0, 0, 1, 11, 0,  1, 0, 1, 23, 0);
    add("t4_g4",    1, 3, 0,  9, 0,  1, 0, 1, 23, 0);
    add("t4_g5",    0, 0, 0,  9, 0,  1, 0, 1, 23, 0);
    add("t4_b4",    0, 0, 1, 13, 0,  0, 1, 1, 36, 0);
    for (int i = 0; i < 5; i++)
      add("t4_stall", 1, 2, 1, 1, 0,  0, 1, 1, 36, 0);
    add("t4_pop_st",1, 2, 0,  0, 1,  0, 0, 0, 36, 0);
    add("t4_idle",  0, 0, 0,  0, 0,  0, 0, 0, 36, 0);

    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst_ir",   in_ready, 1'b0);
    chk("rst_ov",   out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_acc",  acc, '0);
    chk("rst_ovf",  ovf, 1'b0);
    Rst = 1;

    foreach (vq[i]) begin
      @(negedge Clk);
      start = vq[i].st; len = vq[i].ln; in_valid = vq[i].iv;
      prod = vq[i].pr; out_ready = vq[i].ordy;
      @(posedge Clk); #1;
      chk({vq[i].tag, "_ir"},   in_ready,  vq[i].e_ir);
      chk({vq[i].tag, "_ov"},   out_valid, vq[i].e_ov);
      chk({vq[i].tag, "_busy"}, busy,      vq[i].e_busy);
      chk({vq[i].tag, "_acc"},  acc,       vq[i].e_acc);
      chk({vq[i].tag, "_ovf"},  ovf,       vq[i].e_ovf);
    end
    @(negedge Clk);
    idle_inputs();

    // t3: 16-bit accumulator overflow; 24-bit instance does not overflow
    @(negedge Clk); start = 1; len = 2;
    @(negedge Clk); start = 0; in_valid = 1; prod = 16'hFFFF;
    @(negedge Clk);
    @(negedge Clk); in_valid = 0;
    chk("t3_ov16", out_valid_s, 1'b1);
`ifdef PROD_ACCUM_SAT_EN
    chk("t3_acc16", acc_s, 16'hFFFF);
`else
    chk("t3_acc16", acc_s, 16'hFFFE);
`endif
    chk("t3_ovf16", ovf_s, 1'b1);
    chk("t3_acc24", acc, 24'h01FFFE);
    chk("t3_ovf24", ovf, 1'b0);
    pop("t3");
    // ovf clears on the next start
    @(negedge Clk); start = 1; len = 1;
    @(posedge Clk); #1;
    chk("t3_clr_ovf16", ovf_s, 1'b0);
    @(negedge Clk); start = 0; in_valid = 1; prod = 16'd1;
    @(negedge Clk); in_valid = 0;
    chk("t3_re_acc16", acc_s, 16'd1);
    pop("t3b");

    // t5: async reset after 2 of 4 beats
    @(negedge Clk); start = 1; len = 4;
    @(negedge Clk); start = 0; in_valid = 1; prod = 16'd3;
    @(negedge Clk);
    @(negedge Clk); in_valid = 0;
    chk("t5_pre_acc", acc, 24'd6);
    #2 Rst = 0;
    #1;
    chk("t5_ir",   in_ready, 1'b0);
    chk("t5_ov",   out_valid, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_acc",  acc, '0);
    chk("t5_ovf",  ovf, 1'b0);
    @(negedge Clk); Rst = 1;
    @(negedge Clk); start = 1; len = 1;
    @(negedge Clk); start = 0; in_valid = 1; prod = 16'd9;
    @(negedge Clk); in_valid = 0;
    chk("t5_new_ov",  out_valid, 1'b1);
    chk("t5_new_acc", acc, 24'd9);
    pop("t5");

    // t6: random runs against reference sums
    run_rand(1);
    run_rand(2);
    run_rand(17);
    run_rand(255);
    for (int k = 0; k < 3; k++) run_rand($urandom_range(1, 255));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
